// File: rtl/trng_pkg.sv
// trng_pkg: shared sizing constants and types for the TRNG collector slice.
//   WORD_W         - width of an assembled entropy word
//   BIT_CNT_W      - width of the bit-position counter inside a word
//   FIFO_DEPTH     - number of words the output FIFO holds
//   PTR_W / CNT_W  - FIFO pointer width and occupancy-counter width
//   COUNT_W        - width of the popped-word counter
//   WORD_COUNT_MAX - saturation value of the popped-word counter
package trng_pkg;

    localparam int WORD_W         = 8;
    localparam int BIT_CNT_W      = $clog2(WORD_W);
    localparam int FIFO_DEPTH     = 4;
    localparam int PTR_W          = $clog2(FIFO_DEPTH);
    localparam int CNT_W          = PTR_W + 1;
    localparam int COUNT_W        = 8;
    localparam int WORD_COUNT_MAX = 255;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/trng_fifo.sv
// trng_fifo: small synchronous FIFO for assembled entropy words.
//   clk, rst   - clock, asynchronous active-high reset
//   flush      - synchronous clear of pointers and occupancy (has priority)
//   push/wdata - write request and data; accepted when not full, or when
//                full and a pop happens on the same edge
//   pop        - read request; ignored when empty
//   rdata      - oldest entry (0x00 while empty)
//   full/empty - occupancy status
module trng_fifo
    import trng_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  push,
    input  logic  pop,
    input  word_t wdata,
    output word_t rdata,
    output logic  full,
    output logic  empty
);

    word_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    // Gating with empty gives a defined 0x00 head after reset or flush
    // without having to clear the storage array.
    assign rdata = empty ? '0 : mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; only the pointers need one,
    // and rdata is masked while empty so stale contents never show.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/trng_collector.sv
// trng_collector: packs raw entropy bits into bytes and buffers them.
//   clk, rst     - clock, asynchronous active-high reset
//   start        - synchronous flush of all collector state (wins over done)
//   done/raw_bit - one raw sample offered per cycle with done=1
//   data_out     - head word of the 4-entry output FIFO
//   data_valid   - FIFO holds at least one word
//   data_ready   - consumer accept; pop on data_valid && data_ready
//   overflow     - sticky: a completed word was dropped on a full FIFO
//   word_count   - words popped, saturating at 255
// Optional feature: define TRNG_VON_NEUMANN_EN to pass samples through a
// von Neumann debiaser (01 -> 0, 10 -> 1, 00/11 -> nothing).
module trng_collector
    import trng_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               done,
    input  logic               raw_bit,
    output logic [WORD_W-1:0]  data_out,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               overflow,
    output logic [COUNT_W-1:0] word_count
);

    logic                 accept;
    logic                 bit_valid;
    logic                 bit_val;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [BIT_CNT_W-1:0] bit_cnt;
    // Holds the first seven bits of a word; the eighth goes straight into
    // the FIFO together with them on the completing edge.
    logic [WORD_W-2:0]    shift_reg;
    word_t                next_word;

    assign accept = done && !start;

`ifdef TRNG_VON_NEUMANN_EN
    logic pair_full;
    logic pair_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_full <= 1'b0;
            pair_bit  <= 1'b0;
        end else if (start) begin
            pair_full <= 1'b0;
            pair_bit  <= 1'b0;
        end else if (accept) begin
            if (!pair_full) begin
                pair_full <= 1'b1;
                pair_bit  <= raw_bit;
            end else begin
                pair_full <= 1'b0;
            end
        end
    end

    // A differing pair emits its first bit: 01 -> 0, 10 -> 1.
    assign bit_valid = accept && pair_full && (pair_bit != raw_bit);
    assign bit_val   = pair_bit;
`else
    assign bit_valid = accept;
    assign bit_val   = raw_bit;
`endif

    assign next_word = {shift_reg, bit_val};
    assign push      = bit_valid && (bit_cnt == BIT_CNT_W'(WORD_W - 1));
    assign pop       = data_valid && data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (start) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (bit_valid) begin
            shift_reg <= next_word[WORD_W-2:0];
            bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
        end
    end

    trng_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start),
        .push  (push),
        .pop   (pop),
        .wdata (next_word),
        .rdata (data_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign data_valid = !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            word_count <= '0;
        end else if (start) begin
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            if (push && fifo_full && !pop) overflow <= 1'b1;
            if (pop && (word_count != COUNT_W'(WORD_COUNT_MAX)))
                word_count <= word_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: randomized and directed stimulus against a queue-based
// reference model. The model collects bits in a queue, forms words from the
// first eight, and keeps the expected FIFO contents in exp_q; a monitor on
// the falling edge compares status and the head word whenever data_valid=1.
module tb_trng_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       done;
    logic       raw_bit;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       overflow;
    logic [7:0] word_count;

    int n_vec = 0;
    int n_bad = 0;

    trng_collector dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .done       (done),
        .raw_bit    (raw_bit),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];   // expected FIFO contents, oldest first
    bit         bits_q[$];  // accepted bits of the word in progress
    bit         pend_q[$];  // raw samples waiting for a partner (debias)
    bit         m_ovf;
    int         m_wc;
    bit         m_pop;
    bit         m_have;
    logic [7:0] m_word;

    always @(posedge clk or posedge rst) begin
        if (rst || start) begin
            exp_q.delete();
            bits_q.delete();
            pend_q.delete();
            m_ovf = 1'b0;
            m_wc  = 0;
        end else begin
            m_pop  = (exp_q.size() > 0) && data_ready;
            m_have = 1'b0;
            if (done) begin
`ifdef TRNG_VON_NEUMANN_EN
                pend_q.push_back(raw_bit);
                if (pend_q.size() == 2) begin
                    if (pend_q[0] != pend_q[1]) bits_q.push_back(pend_q[0]);
                    pend_q.delete();
                end
`else
                bits_q.push_back(raw_bit);
`endif
                if (bits_q.size() == 8) begin
                    m_word = 8'h00;
                    for (int i = 0; i < 8; i++) m_word = {m_word[6:0], bits_q[i]};
                    bits_q.delete();
                    m_have = 1'b1;
                end
            end
            if (m_pop) begin
                void'(exp_q.pop_front());
                if (m_wc < 255) m_wc++;
            end
            if (m_have) begin
                if (exp_q.size() < 4) exp_q.push_back(m_word);
                else m_ovf = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("data_valid", 32'(data_valid), 32'(exp_q.size() > 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("word_count", 32'(word_count), 32'(m_wc));
            if (data_valid && exp_q.size() > 0)
                check("head_word", 32'(data_out), 32'(exp_q[0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit d, input bit b, input bit r, input bit s);
        done = d; raw_bit = b; data_ready = r; start = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r);
        step(1'b0, 1'b0, r, 1'b0);
    endtask

    // One emitted bit; under debias it is sent as the pair (b, ~b).
    // r_edge is data_ready on the edge that actually accepts the bit.
    task automatic feed_bit(input bit b, input bit r_mid, input bit r_edge);
`ifdef TRNG_VON_NEUMANN_EN
        step(1'b1, b, r_mid, 1'b0);
        step(1'b1, !b, r_edge, 1'b0);
`else
        step(1'b1, b, r_edge, 1'b0);
`endif
    endtask

    task automatic feed_word(input logic [7:0] w, input bit r_body, input bit r_last);
        for (int i = 7; i >= 0; i--)
            feed_bit(w[i], r_body, (i == 0) ? r_last : r_body);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'h00);
        check({tag, "_data_valid"}, 32'(data_valid), 32'h0);
        check({tag, "_overflow"}, 32'(overflow), 32'h0);
        check({tag, "_word_count"}, 32'(word_count), 32'h0);
    endtask

    logic [7:0] w_b2;
    int         r;

    initial begin
        rst = 1'b1; start = 1'b0; done = 1'b0; raw_bit = 1'b0; data_ready = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(1'b0);

        // Basic packing: 1,0,1,1,0,0,1,0 -> 0xB2, valid one cycle after bit 8.
        w_b2 = 8'hB2;
        for (int i = 7; i >= 1; i--) feed_bit(w_b2[i], 1'b0, 1'b0);
        check("pack_valid_before_8th", 32'(data_valid), 32'h0);
        feed_bit(w_b2[0], 1'b0, 1'b0);
        check("pack_valid", 32'(data_valid), 32'h1);
        check("pack_word", 32'(data_out), 32'hB2);
        idle(1'b0);
        check("pack_hold", 32'(data_out), 32'hB2);
        idle(1'b1);
        check("pack_popped_valid", 32'(data_valid), 32'h0);
        check("pack_popped_count", 32'(word_count), 32'h1);

        // Overflow: five all-ones words into a 4-deep FIFO, no pops.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) feed_word(8'hFF, 1'b0, 1'b0);
        check("ovf_before_5th", 32'(overflow), 32'h0);
        feed_word(8'hFF, 1'b0, 1'b0);
        check("ovf_after_5th", 32'(overflow), 32'h1);
        check("ovf_head", 32'(data_out), 32'hFF);
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain_valid", 32'(data_valid), 32'h1);
            idle(1'b1);
        end
        check("ovf_drained", 32'(data_valid), 32'h0);

        // Full FIFO with push and pop on the same edge.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("start_clears_ovf", 32'(overflow), 32'h0);
        feed_word(8'h11, 1'b0, 1'b0);
        feed_word(8'h22, 1'b0, 1'b0);
        feed_word(8'h33, 1'b0, 1'b0);
        feed_word(8'h44, 1'b0, 1'b0);
        check("full_head", 32'(data_out), 32'h11);
        feed_word(8'hA5, 1'b0, 1'b1);
        check("pushpop_no_ovf", 32'(overflow), 32'h0);
        check("pushpop_count", 32'(word_count), 32'h1);
        check("pushpop_head", 32'(data_out), 32'h22);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("pushpop_last_head", 32'(data_out), 32'hA5);
        idle(1'b1);
        check("pushpop_drained", 32'(data_valid), 32'h0);

        // Reset mid-word discards the partial word.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) feed_bit(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midword_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        feed_word(8'hFF, 1'b0, 1'b0);
        check("rst_fresh_word", 32'(data_out), 32'hFF);
        idle(1'b1);
        check("rst_single_word", 32'(data_valid), 32'h0);

        // Start mid-word, coinciding with a done of raw_bit=0.
        repeat (5) feed_bit(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        feed_word(8'hFF, 1'b0, 1'b0);
        check("start_fresh_word", 32'(data_out), 32'hFF);
        idle(1'b1);
        check("start_single_word", 32'(data_valid), 32'h0);

`ifdef TRNG_VON_NEUMANN_EN
        // Debias: pairs 01,10,00,11 repeated -> bits 0,1,... -> 0x55, 0x55.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (8) begin
            step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        check("vn_word0", 32'(data_out), 32'h55);
        idle(1'b1);
        check("vn_word1", 32'(data_out), 32'h55);
        idle(1'b1);
        check("vn_two_words", 32'(data_valid), 32'h0);
`endif

        // Saturation: 260 words popped with data_ready held high.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 260; i++) feed_word(8'($urandom), 1'b1, 1'b1);
        idle(1'b1);
        check("sat_count", 32'(word_count), 32'd255);
        check("sat_empty", 32'(data_valid), 32'h0);

        // Randomized traffic with occasional start and async reset pulses.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            if (r[15:8] == 8'd7) begin
                rst = 1'b1;
                #1 check_reset_outputs("rand_rst");
                #2 rst = 1'b0;
            end
            step(r[0] | r[1], r[2], r[3] | (r[4] & r[5]), r[11:6] == 6'd0);
        end
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
